dtree_sample_streamer: RTL and testbench

//  Byte-serial front end for the combinational decision-tree classifier (top).

---
 rtl/dtree_pkg.sv | 14 +
 rtl/dtree_result_slot.sv | 37 +++
 rtl/dtree_sample_streamer.sv | 112 +++++++++++
 tb/tb_dtree_sample_streamer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtree_pkg.sv
// Shared definitions for the decision-tree classifier, its byte-serial front end
// and the benches that drive them.
package dtree_pkg;

    localparam int NUM_FEATURES = 16;
    localparam int FEAT_W       = 8;
    localparam int CLASS_W      = 4;

    typedef enum logic {
        ST_LOAD,
        ST_EVAL
    } streamer_state_e;

endpackage

// File: rtl/dtree_result_slot.sv
// One-entry valid/ready holding register for a classified sample {index, class}.
// 'free' is high when a new result may be written this cycle.
module dtree_result_slot #(
    parameter int CLASS_W = dtree_pkg::CLASS_W,
    parameter int IDX_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [CLASS_W-1:0] d_class,
    input  logic [IDX_W-1:0]   d_index,
    input  logic               m_ready,
    output logic               m_valid,
    output logic [CLASS_W-1:0] m_class,
    output logic [IDX_W-1:0]   m_index,
    output logic               free
);

    // A draining slot can take a new result in the same cycle.
    assign free = !m_valid || m_ready;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_class <= '0;
            m_index <= '0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_class <= d_class;
            m_index <= d_index;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dtree_sample_streamer.sv
// Deserialises a valid/ready feature byte stream for the combinational tree,
// waits for it to settle and returns {sample index, class} on a result channel.
module dtree_sample_streamer #(
    parameter int NUM_FEATURES  = dtree_pkg::NUM_FEATURES,
    parameter int FEAT_W        = dtree_pkg::FEAT_W,
    parameter int CLASS_W       = dtree_pkg::CLASS_W,
    parameter int SETTLE_CYCLES = 1,
    parameter int IDX_W         = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [FEAT_W-1:0]              s_data,
    input  logic                           s_last,
    output logic [NUM_FEATURES*FEAT_W-1:0] feat_flat,
    input  logic [CLASS_W-1:0]             class_in,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [CLASS_W-1:0]             m_class,
    output logic [IDX_W-1:0]               m_index,
    output logic                           err_len
);
    import dtree_pkg::*;

    localparam int PTR_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_FEATURES - 1);
    localparam logic [SET_W-1:0] SETTLED  = SET_W'(SETTLE_CYCLES);

    streamer_state_e                        state;
    logic [PTR_W-1:0]                       ptr;
    logic                                   dropping;
    logic [SET_W-1:0]                       settle_cnt;
    logic [NUM_FEATURES-1:0][FEAT_W-1:0]    feat_q;
    logic [IDX_W-1:0]                       sample_cnt;
    logic                                   slot_free;
    logic                                   capture;

    assign feat_flat = feat_q;
    assign capture   = (state == ST_EVAL) && (settle_cnt == SETTLED) && slot_free;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_LOAD;
            s_ready    <= 1'b1;
            ptr        <= '0;
            dropping   <= 1'b0;
            settle_cnt <= '0;
            // NOTE: the feature bank is reset because it drives the tree directly and must start at zero.
            feat_q     <= '0;
            sample_cnt <= '0;
            err_len    <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (s_valid && s_ready) begin
                        if (dropping) begin
                            // Discard the tail of an over-long sample up to its s_last.
                            if (s_last) dropping <= 1'b0;
                        end else begin
                            feat_q[ptr] <= s_data;
                            if (ptr == LAST_PTR) begin
                                ptr <= '0;
                                if (s_last) begin
                                    state      <= ST_EVAL;
                                    s_ready    <= 1'b0;
                                    settle_cnt <= '0;
                                end else begin
                                    err_len  <= 1'b1;
                                    dropping <= 1'b1;
                                end
                            end else if (s_last) begin
                                err_len <= 1'b1;
                                ptr     <= '0;
                            end else begin
                                ptr <= ptr + PTR_W'(1);
                            end
                        end
                    end
                end
                ST_EVAL: begin
                    if (settle_cnt != SETTLED) begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end else if (capture) begin
                        state      <= ST_LOAD;
                        s_ready    <= 1'b1;
                        sample_cnt <= sample_cnt + IDX_W'(1);
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    dtree_result_slot #(
        .CLASS_W (CLASS_W),
        .IDX_W   (IDX_W)
    ) u_slot (
        .clk     (clk),
        .rst     (rst),
        .load    (capture),
        .d_class (class_in),
        .d_index (sample_cnt),
        .m_ready (m_ready),
        .m_valid (m_valid),
        .m_class (m_class),
        .m_index (m_index),
        .free    (slot_free)
    );

endmodule

// File: tb/tb_dtree_sample_streamer.sv
// Bench for dtree_sample_streamer: plays the tree with a behavioural classifier
// and scoreboards {index, class} results; a 4-bit-index twin exercises wrap.
module tb_dtree_sample_streamer;
    import dtree_pkg::*;

    localparam int N      = NUM_FEATURES;
    localparam int IDX_W  = 16;
    localparam int BUDGET = 2000;

    typedef logic [FEAT_W-1:0] sample_t [N];
    typedef struct {
        logic [IDX_W-1:0]   idx;
        logic [CLASS_W-1:0] cls;
    } result_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                   s_valid = 1'b0;
    logic                   s_last  = 1'b0;
    logic [FEAT_W-1:0]      s_data  = '0;
    logic                   m_ready = 1'b0;

    logic                   s_ready, s_ready4;
    logic [N*FEAT_W-1:0]    feat_flat, feat_flat4;
    logic [CLASS_W-1:0]     class_in, class_in4, m_class, m_class4;
    logic                   m_valid, m_valid4, err_len, err_len4;
    logic [IDX_W-1:0]       m_index;
    logic [3:0]             m_index4;

    dtree_sample_streamer #(.SETTLE_CYCLES(1), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .feat_flat(feat_flat), .class_in(class_in), .m_valid(m_valid),
        .m_ready(m_ready), .m_class(m_class), .m_index(m_index), .err_len(err_len)
    );

    dtree_sample_streamer #(.SETTLE_CYCLES(1), .IDX_W(4)) dut_w4 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready4), .s_data(s_data),
        .s_last(s_last), .feat_flat(feat_flat4), .class_in(class_in4), .m_valid(m_valid4),
        .m_ready(m_ready), .m_class(m_class4), .m_index(m_index4), .err_len(err_len4)
    );

    // Behavioural decision tree used both as the DUT's class source and as the golden model.
    function automatic logic [CLASS_W-1:0] tree_model(input sample_t x);
        logic [7:0] a, b;
        if (x[0] < 8'd128) begin
            a = x[9];
            b = x[12];
            tree_model = (x[3] > x[7]) ? {2'b00, a[1:0]} : 4'd4 + {2'b00, b[1:0]};
        end else begin
            a = x[5];
            b = x[11];
            tree_model = (x[14] >= x[2]) ? 4'd8 + {1'b0, a[2:0]} : 4'd15 - {2'b00, b[1:0]};
        end
    endfunction

    function automatic sample_t unpack(input logic [N*FEAT_W-1:0] f);
        sample_t x;
        for (int k = 0; k < N; k++) x[k] = f[k*FEAT_W +: FEAT_W];
        return x;
    endfunction

    always_comb class_in  = tree_model(unpack(feat_flat));
    always_comb class_in4 = tree_model(unpack(feat_flat4));

    int              checks = 0;
    int              errors = 0;
    int              seen   = 0;
    logic            rand_ready = 1'b0;
    result_t         sb[$];
    logic [IDX_W-1:0] exp_idx = '0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Result monitor, sampling just before each rising edge.
    initial forever begin
        result_t r;
        @(negedge clk);
        #4;
        if (!rst && m_valid && m_ready) begin
            check("result_expected", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                r = sb.pop_front();
                seen++;
                check("m_index", m_index, r.idx);
                check("m_class", m_class, r.cls);
                check("w4_m_valid", m_valid4, 1'b1);
                check("w4_m_index", m_index4, r.idx[3:0]);
                check("w4_m_class", m_class4, r.cls);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic send_byte(input logic [FEAT_W-1:0] d, input logic l, input int max_gap);
        int n;
        if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        n = 0;
        while (!s_ready && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (n >= BUDGET) check("s_ready_wait", s_ready, 1'b1);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_sample(input sample_t x, input int max_gap);
        for (int k = 0; k < N; k++) send_byte(x[k], k == N - 1, max_gap);
        sb.push_back('{idx: exp_idx, cls: tree_model(x)});
        exp_idx++;
    endtask

    function automatic sample_t rand_sample();
        sample_t x;
        for (int k = 0; k < N; k++) x[k] = FEAT_W'($urandom);
        return x;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        exp_idx = '0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_s_ready"}, s_ready, 1'b1);
        check({tag, "_feat_flat"}, feat_flat, '0);
        check({tag, "_m_valid"}, m_valid, 1'b0);
        check({tag, "_m_class"}, m_class, '0);
        check({tag, "_m_index"}, m_index, '0);
        check({tag, "_err_len"}, err_len, 1'b0);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) check({tag, "_drain"}, sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        sample_t x;
        sample_t y;

        // 1: single sample 0..15, latency and reset state.
        do_reset();
        check_reset_state("rst");
        m_ready = 1'b1;
        for (int k = 0; k < N; k++) x[k] = FEAT_W'(k);
        send_sample(x, 0);
        check("t1_lat0_valid", m_valid, 1'b0);
        check("t1_eval_s_ready", s_ready, 1'b0);
        @(negedge clk);
        check("t1_lat1_valid", m_valid, 1'b0);
        @(negedge clk);
        check("t1_lat2_valid", m_valid, 1'b1);
        check("t1_index", m_index, '0);
        check("t1_class", m_class, tree_model(x));
        check("t1_reload_s_ready", s_ready, 1'b1);
        wait_drain("t1");

        // 2: back-to-back samples with the result channel blocked.
        do_reset();
        m_ready = 1'b0;
        send_sample(rand_sample(), 0);
        send_sample(rand_sample(), 0);
        repeat (6) @(negedge clk);
        check("t2_stall_s_ready", s_ready, 1'b0);
        check("t2_stall_valid", m_valid, 1'b1);
        check("t2_stall_index", m_index, '0);
        fork
            send_sample(rand_sample(), 0);
            begin
                repeat (3) @(negedge clk);
                m_ready = 1'b1;
            end
        join
        wait_drain("t2");
        check("t2_seen", seen, 4);

        // 3: short sample (s_last on byte 5).
        do_reset();
        m_ready = 1'b1;
        x = rand_sample();
        for (int k = 0; k < 6; k++) send_byte(x[k], k == 5, 0);
        repeat (4) @(negedge clk);
        check("t3_err_len", err_len, 1'b1);
        check("t3_no_valid", m_valid, 1'b0);
        check("t3_s_ready", s_ready, 1'b1);
        send_sample(rand_sample(), 1);
        wait_drain("t3");
        check("t3_err_sticky", err_len, 1'b1);

        // 4: over-long sample, 19 bytes dropped.
        do_reset();
        m_ready = 1'b1;
        for (int k = 0; k < N; k++) send_byte(FEAT_W'($urandom), 1'b0, 0);
        check("t4_err_len", err_len, 1'b1);
        for (int k = 0; k < 3; k++) send_byte(FEAT_W'($urandom), k == 2, 0);
        repeat (4) @(negedge clk);
        check("t4_no_valid", m_valid, 1'b0);
        send_sample(rand_sample(), 0);
        wait_drain("t4");

        // 5: reset during byte 8 with a result pending.
        do_reset();
        m_ready = 1'b0;
        send_sample(rand_sample(), 0);
        repeat (3) @(negedge clk);
        check("t5_pending_valid", m_valid, 1'b1);
        y = rand_sample();
        for (int k = 0; k < 8; k++) send_byte(y[k], 1'b0, 0);
        s_valid = 1'b1;
        s_data  = y[8];
        rst     = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        s_valid = 1'b0;
        sb.delete();
        exp_idx = '0;
        check_reset_state("t5");
        m_ready = 1'b1;
        send_sample(rand_sample(), 0);
        wait_drain("t5");

        // 6: randomized gaps and back-pressure; index wraps on the 4-bit twin.
        do_reset();
        seen = 0;
        rand_ready = 1'b1;
        for (int i = 0; i < 200; i++) send_sample(rand_sample(), 2);
        rand_ready = 1'b0;
        m_ready = 1'b1;
        wait_drain("t6");
        check("t6_seen", seen, 200);
        check("t6_err_len", err_len, 1'b0);
        check("t6_w4_err_len", err_len4, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
